// File: rtl/zcd_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zcd_framer_pkg                                                       |
// | Shared types and trailer helpers for the zero-crossing AXIS framer.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package zcd_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_TRAILER = 2'd2
  } framer_state_e;

  // The trailer is built at its narrowest form (36 bits): four flag bits on
  // top of a 32-bit sample count. Wider buses pad zeros between the two.
  localparam int TRL_W     = 36;
  localparam int TRL_MARK  = 35;
  localparam int TRL_TRUNC = 34;
  localparam int TRL_ABORT = 33;
  localparam int TRL_OVF   = 32;

  function automatic logic [TRL_W-1:0] build_trailer(
    input logic        trunc,
    input logic        abort,
    input logic        ovf,
    input logic [31:0] count
  );
    logic [TRL_W-1:0] w;
    w            = '0;
    w[TRL_MARK]  = 1'b1;
    w[TRL_TRUNC] = trunc;
    w[TRL_ABORT] = abort;
    w[TRL_OVF]   = ovf;
    w[31:0]      = count;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft                                                       |
// | Single-clock first-word-fall-through FIFO with registered occupancy. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never
  // frees room for a push.
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  // Head word is forced to zero when empty so the bus is quiet out of reset.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset since empty masks the output.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/zcd_axis_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zcd_axis_framer                                                      |
// | Packs zero-crossing capture windows into AXI4-Stream packets, each   |
// | closed by a trailer word with sample count and status flags.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module zcd_axis_framer
  import zcd_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 46,
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  zc_start,
  input  logic                  zc_count_valid,
  input  logic                  save_gate,
  input  logic                  cfg_enable,
  input  logic [REG_WIDTH-1:0]  cfg_max_samples,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           frames_done,
  output logic                  overflow,
  output logic                  busy
);

  // Data words always leave with the marker bit cleared.
  localparam logic [DATA_WIDTH-1:0] c_payload_mask = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  framer_state_e         r_state;
  logic [REG_WIDTH-1:0]  r_count;
  logic                  r_trunc;
  logic                  r_abort;
  logic                  r_ovf_frame;
  logic                  r_overflow;
  logic [15:0]           r_frames_done;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_start;
  logic                  w_cap;
  logic                  w_at_max;
  logic                  w_accept;
  logic                  w_smp_wr;
  logic                  w_smp_drop;
  logic                  w_trl_wr;
  logic                  w_reach;
  logic [REG_WIDTH-1:0]  w_cnt_base;
  logic [REG_WIDTH-1:0]  w_cnt_next;
  logic [TRL_W-1:0]      w_trl_min;
  logic [DATA_WIDTH-1:0] w_trl_word;
  logic [DATA_WIDTH-1:0] w_fifo_din;

  assign w_start  = (r_state == ST_IDLE) && cfg_enable && save_gate && zc_start;
  assign w_cap    = (r_state == ST_CAPTURE);
  // Once the limit is reached no more samples are taken in this window.
  assign w_at_max = (cfg_max_samples != '0) && (r_count >= cfg_max_samples);
  assign w_accept = w_start || (w_cap && !w_at_max);
  assign w_smp_wr   = w_accept && s_valid && !w_full;
  assign w_smp_drop = w_accept && s_valid && w_full;
  assign w_trl_wr   = (r_state == ST_TRAILER) && !w_full;

  // Start cycle counts from zero regardless of the previous frame's count.
  assign w_cnt_base = w_start ? '0 : r_count;
  assign w_cnt_next = (w_smp_wr && (w_cnt_base != '1)) ? w_cnt_base + REG_WIDTH'(1)
                                                       : w_cnt_base;
  assign w_reach    = (cfg_max_samples != '0) && (w_cnt_next >= cfg_max_samples);

  assign w_trl_min  = build_trailer(r_trunc, r_abort, r_ovf_frame, 32'(r_count));

  // Spread the narrow trailer across the bus: flags on top, count at bottom.
  always_comb begin
    w_trl_word                      = '0;
    w_trl_word[DATA_WIDTH-1 -: 4]   = w_trl_min[TRL_MARK:TRL_OVF];
    w_trl_word[31:0]                = w_trl_min[31:0];
  end

  assign w_fifo_din = w_trl_wr ? w_trl_word : (s_data & c_payload_mask);

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_smp_wr || w_trl_wr),
    .wr_data (w_fifo_din),
    .full    (w_full),
    .rd_en   (m_axis_tready),
    .rd_data (m_axis_tdata),
    .empty   (w_empty)
  );

  // Capture FSM, window counters and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_trunc       <= 1'b0;
      r_abort       <= 1'b0;
      r_ovf_frame   <= 1'b0;
      r_overflow    <= 1'b0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_CAPTURE;
            r_count     <= w_cnt_next;
            r_trunc     <= 1'b0;
            r_abort     <= 1'b0;
            r_ovf_frame <= w_smp_drop;
          end
        end
        ST_CAPTURE: begin
          r_count <= w_cnt_next;
          if (w_smp_drop) r_ovf_frame <= 1'b1;
          // Exit priority: normal end, then truncation, then abort.
          if (zc_count_valid) begin
            r_state <= ST_TRAILER;
          end else if (w_reach) begin
            r_state <= ST_TRAILER;
            r_trunc <= 1'b1;
          end else if (!cfg_enable) begin
            r_state <= ST_TRAILER;
            r_abort <= 1'b1;
          end
        end
        ST_TRAILER: begin
          if (!w_full) begin
            r_state       <= ST_IDLE;
            r_frames_done <= r_frames_done + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_smp_drop) r_overflow <= 1'b1;
    end
  end

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tlast  = m_axis_tdata[DATA_WIDTH-1];
  assign frames_done   = r_frames_done;
  assign overflow      = r_overflow;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_zcd_axis_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_zcd_axis_framer                                                   |
// | Directed self-checking bench for zcd_axis_framer (16-deep FIFO).     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_zcd_axis_framer;

  localparam int DW = 46;
  localparam int RW = 32;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          zc_start;
  logic          zc_count_valid;
  logic          save_gate;
  logic          cfg_enable;
  logic [RW-1:0] cfg_max_samples;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [15:0]   frames_done;
  logic          overflow;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;

  logic [DW:0] rxq[$];

  typedef struct {
    int          n;
    int          max;
    bit          gate;
    bit          abort_end;
    int          exp_words;
    bit          exp_trl;
    logic [DW-1:0] trl;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  zcd_axis_framer #(
    .DATA_WIDTH (DW),
    .REG_WIDTH  (RW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .zc_start        (zc_start),
    .zc_count_valid  (zc_count_valid),
    .save_gate       (save_gate),
    .cfg_enable      (cfg_enable),
    .cfg_max_samples (cfg_max_samples),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .frames_done     (frames_done),
    .overflow        (overflow),
    .busy            (busy)
  );

  // Record every word that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (rst && m_axis_tvalid && m_axis_tready)
      rxq.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] smp(input int i);
    logic [DW-2:0] lo;
    lo = (DW-1)'(i * 7919 + 12345);
    return {i[0], lo};
  endfunction

  function automatic logic [DW-1:0] expw(input int i);
    logic [DW-1:0] v;
    v = smp(i);
    v[DW-1] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int n, input bit gate, input bit abort_end);
    for (int i = 0; i < n; i++) begin
      zc_start       = (i == 0);
      save_gate      = gate;
      s_valid        = 1'b1;
      s_data         = smp(i);
      zc_count_valid = (!abort_end && (i == n - 1));
      tick();
    end
    s_valid = 1'b0; zc_start = 1'b0; zc_count_valid = 1'b0; save_gate = 1'b0;
    if (abort_end) begin
      cfg_enable = 1'b0;
      tick();
      cfg_enable = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((busy || m_axis_tvalid) && c < 5000) begin
      tick();
      c++;
    end
    chk({name, " drain"}, 64'(c < 5000), 64'd1);
  endtask

  task automatic check_packet(input string name, input int n_words, input bit has_trl,
                              input logic [DW-1:0] trl);
    int nbad;
    int first;
    nbad = 0;
    first = -1;
    chk({name, " len"}, 64'(rxq.size()), 64'(n_words + int'(has_trl)));
    for (int k = 0; k < n_words && k < rxq.size(); k++) begin
      if (rxq[k] !== {1'b0, expw(k)}) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s data: %0d bad words, first at %0d got 0x%0h expected 0x%0h",
               name, nbad, first, rxq[first], {1'b0, expw(first)});
    end
    if (has_trl && rxq.size() > 0)
      chk({name, " trailer"}, 64'(rxq[rxq.size()-1]), 64'({1'b1, trl}));
    rxq.delete();
  endtask

  initial begin
    vt[0] = '{n: 1000, max: 0,  gate: 1'b1, abort_end: 1'b0, exp_words: 1000, exp_trl: 1'b1, trl: 46'h2000_0000_03E8};
    vt[1] = '{n: 5,    max: 0,  gate: 1'b0, abort_end: 1'b0, exp_words: 0,    exp_trl: 1'b0, trl: 46'h0};
    vt[2] = '{n: 5,    max: 0,  gate: 1'b1, abort_end: 1'b0, exp_words: 5,    exp_trl: 1'b1, trl: 46'h2000_0000_0005};
    vt[3] = '{n: 100,  max: 16, gate: 1'b1, abort_end: 1'b0, exp_words: 16,   exp_trl: 1'b1, trl: 46'h3000_0000_0010};
    vt[4] = '{n: 7,    max: 0,  gate: 1'b1, abort_end: 1'b1, exp_words: 7,    exp_trl: 1'b1, trl: 46'h2800_0000_0007};
    vt[5] = '{n: 2,    max: 0,  gate: 1'b1, abort_end: 1'b0, exp_words: 2,    exp_trl: 1'b1, trl: 46'h2000_0000_0002};

    rst = 1'b0; s_data = '0; s_valid = 1'b0; zc_start = 1'b0; zc_count_valid = 1'b0;
    save_gate = 1'b0; cfg_enable = 1'b1; cfg_max_samples = '0; m_axis_tready = 1'b1;
    tick(); tick();
    chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset frames", 64'(frames_done), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    tick(); tick();

    // Table-driven frames with an unstalled sink.
    for (int r = 0; r < 6; r++) begin
      cfg_max_samples = RW'(vt[r].max);
      drive_frame(vt[r].n, vt[r].gate, vt[r].abort_end);
      wait_idle($sformatf("row%0d", r));
      check_packet($sformatf("row%0d", r), vt[r].exp_words, vt[r].exp_trl, vt[r].trl);
      if (vt[r].exp_trl) exp_frames++;
      chk($sformatf("row%0d frames", r), 64'(frames_done), 64'(exp_frames));
    end
    cfg_max_samples = '0;
    chk("overflow clean", 64'(overflow), 64'd0);

    // Backpressure: 20 samples into a 16-deep FIFO with the sink stalled.
    m_axis_tready = 1'b0;
    drive_frame(20, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("bp busy", 64'(busy), 64'd1);
    chk("bp overflow", 64'(overflow), 64'd1);
    chk("bp tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("bp head", 64'(m_axis_tdata), 64'(expw(0)));
    tick(); tick(); tick();
    chk("bp hold", 64'(m_axis_tdata), 64'(expw(0)));
    chk("bp tlast", 64'(m_axis_tlast), 64'd0);
    m_axis_tready = 1'b1;
    wait_idle("bp");
    check_packet("bp", 16, 1'b1, 46'h2400_0000_0010);
    exp_frames++;
    chk("bp frames", 64'(frames_done), 64'(exp_frames));

    // Normal end, limit reached and enable drop all in one cycle.
    cfg_max_samples = 32'd4;
    for (int i = 0; i < 4; i++) begin
      zc_start = (i == 0); save_gate = 1'b1; s_valid = 1'b1; s_data = smp(i);
      zc_count_valid = (i == 3);
      cfg_enable = (i != 3);
      tick();
    end
    s_valid = 1'b0; zc_start = 1'b0; zc_count_valid = 1'b0; save_gate = 1'b0;
    cfg_enable = 1'b1;
    wait_idle("simul");
    check_packet("simul", 4, 1'b1, 46'h2000_0000_0004);
    cfg_max_samples = '0;

    // Reset in the middle of a stalled packet.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      zc_start = (i == 0); save_gate = 1'b1; s_valid = 1'b1; s_data = smp(i);
      tick();
    end
    s_valid = 1'b0; zc_start = 1'b0; save_gate = 1'b0;
    chk("pre-rst busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst frames", 64'(frames_done), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    tick(); tick();
    rst = 1'b1;
    rxq.delete();
    tick();
    m_axis_tready = 1'b1;
    drive_frame(3, 1'b1, 1'b0);
    wait_idle("post-rst");
    check_packet("post-rst", 3, 1'b1, 46'h2000_0000_0003);
    chk("post-rst frames", 64'(frames_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zcd_axis_framer.md
# zcd_axis_framer

Packetizer on the receiving side of the zero-crossing detector. Takes the ADC sample stream (marker MSB set by the detector), the detector's start pulse, end-of-window count and save gate, and emits whole-period capture windows as AXI4-Stream packets toward the DMA. Each packet has a trailer word carrying the sample count and status flags. Sits between the detector and the AXIS data FIFO/DMA in the AD9226 capture path.

## Interface
- DATA_WIDTH, 46: sample/tdata width; must be ≥ 36.
- REG_WIDTH, 32: config/count width.
- FIFO_DEPTH, 512: output FIFO depth, power of two.

- clk  in  1  sample clock
- rst  in  1  asynchronous, active-low reset
- s_data  in  DATA_WIDTH  ADC sample; MSB is the detector's end-marker and is ignored here
- s_valid  in  1  s_data valid this cycle (no backpressure toward source)
- zc_start  in  1  one-cycle pulse, rising zero crossing
- zc_count_valid  in  1  one-cycle pulse, detector finished its period window
- save_gate  in  1  high when the current period set is to be saved
- cfg_enable  in  1  framer enable
- cfg_max_samples  in  REG_WIDTH  truncation limit per packet (0 = no limit)
- m_axis_tdata  out  DATA_WIDTH  packet word
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  set on trailer word only
- frames_done  out  16  wrapping count of trailers written
- overflow  out  1  sticky; set on any dropped sample, cleared only by reset
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CAPTURE, TRAILER.
- IDLE: on cfg_enable && save_gate && zc_start, enter CAPTURE. A sample with s_valid in that same cycle is the first sample. Clear sample count and frame flags.
- CAPTURE: each s_valid writes {1'b0, s_data[DATA_WIDTH-2:0]} to the FIFO and increments the count.
  - save_gate falling mid-capture has no effect; it only qualifies the start.
- CAPTURE exits to TRAILER on the first of these events:
  - zc_count_valid: normal end. The sample in that cycle is still written.
  - count reaches cfg_max_samples (nonzero): set truncated. No further samples are written.
  - cfg_enable low: set aborted.
- Simultaneous exit events: normal end has priority over truncated, and truncated over aborted. Only the highest-priority flag is set.
- FIFO full while a sample is valid in CAPTURE: the sample is dropped, the count is not incremented, and both the in-frame overflow flag and the sticky overflow are set.
- TRAILER: write the trailer word when the FIFO is not full, then return to IDLE and increment frames_done (wraps at 0xFFFF→0). While waiting in TRAILER, samples are ignored and not flagged.
- Trailer word layout:
  - bit DATA_WIDTH-1 = 1
  - DATA_WIDTH-2 = truncated
  - DATA_WIDTH-3 = aborted
  - DATA_WIDTH-4 = overflow-in-frame
  - [31:0] = samples written
  - all other bits 0
- Push is blocked when the FIFO is full, even if a pop occurs in the same cycle. The full flag comes from the registered occupancy.
- The count saturates at 2^REG_WIDTH−1.

## Timing
- Reset values (async assert, sync release): all outputs 0, state IDLE, FIFO empty.
- Latency: a sample written at edge N appears on m_axis_tdata at edge N+1 if the FIFO was empty (first-word-fall-through).
- AXIS handshake:
  - m_axis_tvalid = FIFO not empty.
  - A word transfers on tvalid && tready.
  - tdata and tlast hold stable while tvalid && !tready.
- The earliest new capture starts in the cycle after the trailer write. zc_start during CAPTURE or TRAILER is ignored.
- Reset mid-packet discards the FIFO contents. A partial packet is never completed.

## Structure
- Package zcd_framer_pkg holds:
  - state enum
  - trailer bit-position localparams (TRL_MARK, TRL_TRUNC, TRL_ABORT, TRL_OVF)
  - trailer-word build function
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH): registered count, full/empty, async active-low reset.
- The framer contains the FSM, counters and trailer mux only.

## Test plan
- Normal window: zc_start with save_gate=1, 1000 valid samples, zc_count_valid, tready=1 → 1000 words with MSB=0, then trailer 0x2000_0000_03E8 (DATA_WIDTH=46) with tlast=1; frames_done=1.
- Gating: zc_start with save_gate=0 → no output. The next zc_start with gate=1 → packet produced.
- Truncation: cfg_max_samples=16, 100 samples → 16 data words plus a trailer with truncated=1, [31:0]=16.
- Backpressure/overflow: FIFO_DEPTH=16, tready=0, 20 samples, then end → 16 words in FIFO, overflow=1, 4 samples dropped, trailer stalls until tready=1. Trailer then shows count 16, ovf=1, and tdata is held stable during stalls.
- Simultaneous events: zc_count_valid in the same cycle as count hits max and cfg_enable falls → trailer flags all 0 except the marker.
- Reset mid-packet: rst low after 10 samples → tvalid=0 and busy=0 immediately. A clean packet follows after release.
